node_ni: RTL and testbench

Parametrised network interface between a processing element and the local (fifth) port of a cluster router. It packs PE words into addressed flits, queues them, and sends them to the router only while it holds router credits. It buffers ejected flits for the PE and returns one credit per slot freed. When the destination equals the node's own address, it loops the flit back locally instead of sending it into the network, and it keeps traffic counters and sticky error flags.

---
 rtl/node_ni.sv | 174 +++++++++++++++++
 tb/tb_node_ni.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/node_ni.sv
// Network interface joining a processing element to the local router port:
// credit-based injection, ejection buffering with credit return, and local loopback.
module node_ni #(
   parameter int DATA_W      = 16,
   parameter int INJ_DEPTH   = 4,
   parameter int EJ_DEPTH    = 4,
   parameter int RTR_CREDITS = 4,
   parameter int LOOPBACK    = 1,
   parameter int CNT_W       = 16,
   localparam int FLIT_W     = DATA_W + 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        my_cluster,
   input  logic [1:0]        my_local,
   input  logic [DATA_W-1:0] pe_data_in,
   input  logic [1:0]        pe_dst_cluster,
   input  logic [1:0]        pe_dst_local,
   input  logic              pe_valid,
   output logic              pe_ready,
   output logic [FLIT_W-1:0] inj_flit,
   output logic              inj_valid,
   input  logic              inj_credit,
   input  logic [FLIT_W-1:0] ej_flit,
   input  logic              ej_valid,
   output logic              ej_credit,
   output logic [DATA_W-1:0] pe_data_out,
   output logic              pe_out_valid,
   input  logic              pe_out_ready,
   output logic [CNT_W-1:0]  sent_cnt,
   output logic [CNT_W-1:0]  recv_cnt,
   output logic [2:0]        err
);

   localparam int INJ_AW = $clog2(INJ_DEPTH);
   localparam int INJ_CW = $clog2(INJ_DEPTH + 1);
   localparam int EJ_AW  = $clog2(EJ_DEPTH);
   localparam int EJ_CW  = $clog2(EJ_DEPTH + 1);
   localparam int CR_W   = $clog2(RTR_CREDITS + 1);
   localparam int SUM_W  = EJ_CW + 1;

   logic [FLIT_W-1:0] inj_mem_q [INJ_DEPTH];
   logic [FLIT_W-1:0] ej_mem_q  [EJ_DEPTH];
   logic              ej_net_q  [EJ_DEPTH];

   logic [INJ_AW-1:0] inj_wr_q, inj_wr_d, inj_rd_q, inj_rd_d;
   logic [INJ_CW-1:0] inj_cnt_q, inj_cnt_d;
   logic [EJ_AW-1:0]  ej_wr_q, ej_wr_d, ej_rd_q, ej_rd_d;
   logic [EJ_CW-1:0]  ej_cnt_q, ej_cnt_d;
   logic [EJ_CW-1:0]  held_q, held_d;
   logic [CR_W-1:0]   credits_q, credits_d;
   logic [FLIT_W-1:0] inj_flit_q, inj_flit_d;
   logic              inj_valid_q, inj_valid_d;
   logic              ej_credit_q, ej_credit_d;
   logic [CNT_W-1:0]  sent_q, sent_d, recv_q, recv_d;
   logic [2:0]        err_q, err_d;

   logic [3:0]        own_addr;
   logic [FLIT_W-1:0] inj_head;
   logic              inj_empty, ej_full, ej_empty;
   logic              push, is_cand, send, net_wr, loop_mv, inj_pop, ej_wr, pop, room;
   logic [FLIT_W-1:0] ej_wr_flit;

   always_comb begin
      own_addr   = {my_cluster, my_local};
      inj_head   = inj_mem_q[inj_rd_q];
      inj_empty  = (inj_cnt_q == '0);
      ej_empty   = (ej_cnt_q == '0);
      ej_full    = (ej_cnt_q == EJ_CW'(EJ_DEPTH));
      push       = pe_valid && (inj_cnt_q != INJ_CW'(INJ_DEPTH));
      is_cand    = (LOOPBACK != 0) && !inj_empty && (inj_head[FLIT_W-1 -: 4] == own_addr);
      send       = !inj_empty && !is_cand && (credits_q != '0);
      // Slots the router may still fill are reserved; loopback only uses the rest.
      room       = (SUM_W'(ej_cnt_q) + SUM_W'(held_q)) < SUM_W'(EJ_DEPTH);
      net_wr     = ej_valid && !ej_full;
      loop_mv    = is_cand && !ej_valid && room;
      inj_pop    = send || loop_mv;
      ej_wr      = net_wr || loop_mv;
      ej_wr_flit = ej_valid ? ej_flit : inj_head;
      pop        = !ej_empty && pe_out_ready;
   end

   always_comb begin
      inj_wr_d    = push ? inj_wr_q + INJ_AW'(1) : inj_wr_q;
      inj_rd_d    = inj_pop ? inj_rd_q + INJ_AW'(1) : inj_rd_q;
      inj_cnt_d   = inj_cnt_q;
      if (push && !inj_pop) inj_cnt_d = inj_cnt_q + INJ_CW'(1);
      else if (!push && inj_pop) inj_cnt_d = inj_cnt_q - INJ_CW'(1);

      ej_wr_d     = ej_wr ? ej_wr_q + EJ_AW'(1) : ej_wr_q;
      ej_rd_d     = pop ? ej_rd_q + EJ_AW'(1) : ej_rd_q;
      ej_cnt_d    = ej_cnt_q;
      if (ej_wr && !pop) ej_cnt_d = ej_cnt_q + EJ_CW'(1);
      else if (!ej_wr && pop) ej_cnt_d = ej_cnt_q - EJ_CW'(1);

      inj_flit_d  = send ? inj_head : inj_flit_q;
      inj_valid_d = send;
      ej_credit_d = pop && ej_net_q[ej_rd_q];
      sent_d      = send ? sent_q + CNT_W'(1) : sent_q;
      recv_d      = pop ? recv_q + CNT_W'(1) : recv_q;
      err_d       = err_q;

      credits_d   = credits_q;
      if (inj_credit && !send) begin
         if (credits_q == CR_W'(RTR_CREDITS)) err_d[0] = 1'b1;
         else credits_d = credits_q + CR_W'(1);
      end else if (!inj_credit && send) begin
         credits_d = credits_q - CR_W'(1);
      end

      held_d = held_q;
      if (ej_credit_q && !ej_valid && held_q != EJ_CW'(EJ_DEPTH)) held_d = held_q + EJ_CW'(1);
      else if (!ej_credit_q && ej_valid && held_q != '0) held_d = held_q - EJ_CW'(1);

      if (ej_valid && ej_full) err_d[1] = 1'b1;
      if (ej_valid && ej_flit[FLIT_W-1 -: 4] != own_addr) err_d[2] = 1'b1;
   end

   // FIFO storage carries no reset; occupancy counters alone define validity.
   always_ff @(posedge clk) begin
      if (push) inj_mem_q[inj_wr_q] <= {pe_dst_cluster, pe_dst_local, pe_data_in};
      if (ej_wr) begin
         ej_mem_q[ej_wr_q] <= ej_wr_flit;
         ej_net_q[ej_wr_q] <= net_wr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inj_wr_q    <= '0;
         inj_rd_q    <= '0;
         inj_cnt_q   <= '0;
         ej_wr_q     <= '0;
         ej_rd_q     <= '0;
         ej_cnt_q    <= '0;
         held_q      <= EJ_CW'(EJ_DEPTH);
         credits_q   <= CR_W'(RTR_CREDITS);
         inj_flit_q  <= '0;
         inj_valid_q <= 1'b0;
         ej_credit_q <= 1'b0;
         sent_q      <= '0;
         recv_q      <= '0;
         err_q       <= '0;
      end else begin
         inj_wr_q    <= inj_wr_d;
         inj_rd_q    <= inj_rd_d;
         inj_cnt_q   <= inj_cnt_d;
         ej_wr_q     <= ej_wr_d;
         ej_rd_q     <= ej_rd_d;
         ej_cnt_q    <= ej_cnt_d;
         held_q      <= held_d;
         credits_q   <= credits_d;
         inj_flit_q  <= inj_flit_d;
         inj_valid_q <= inj_valid_d;
         ej_credit_q <= ej_credit_d;
         sent_q      <= sent_d;
         recv_q      <= recv_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      pe_ready     = (inj_cnt_q != INJ_CW'(INJ_DEPTH));
      inj_flit     = inj_flit_q;
      inj_valid    = inj_valid_q;
      ej_credit    = ej_credit_q;
      pe_out_valid = !ej_empty;
      pe_data_out  = ej_empty ? '0 : ej_mem_q[ej_rd_q][DATA_W-1:0];
      sent_cnt     = sent_q;
      recv_cnt     = recv_q;
      err          = err_q;
   end

endmodule

// File: tb/tb_node_ni.sv
// Directed self-checking bench for node_ni: credits, back-pressure, ejection,
// loopback (with a LOOPBACK=0 twin sharing the inputs), errors and reset.
module tb_node_ni;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  my_cluster, my_local, pe_dst_cluster, pe_dst_local;
   logic [15:0] pe_data_in, pe_data_out, pe_data_out_b;
   logic        pe_valid, pe_ready, pe_ready_b;
   logic [19:0] inj_flit, inj_flit_b, ej_flit;
   logic        inj_valid, inj_valid_b, inj_credit, ej_valid, ej_credit, ej_credit_b;
   logic        pe_out_valid, pe_out_valid_b, pe_out_ready;
   logic [15:0] sent_cnt, recv_cnt, sent_cnt_b, recv_cnt_b;
   logic [2:0]  err, err_b;

   int compared = 0;
   int mismatched = 0;
   int accepts, inj_pulses, ejc_pulses;

   node_ni #(.LOOPBACK(1)) dut (
      .clk(clk), .rst(rst), .my_cluster(my_cluster), .my_local(my_local),
      .pe_data_in(pe_data_in), .pe_dst_cluster(pe_dst_cluster), .pe_dst_local(pe_dst_local),
      .pe_valid(pe_valid), .pe_ready(pe_ready), .inj_flit(inj_flit), .inj_valid(inj_valid),
      .inj_credit(inj_credit), .ej_flit(ej_flit), .ej_valid(ej_valid), .ej_credit(ej_credit),
      .pe_data_out(pe_data_out), .pe_out_valid(pe_out_valid), .pe_out_ready(pe_out_ready),
      .sent_cnt(sent_cnt), .recv_cnt(recv_cnt), .err(err)
   );

   node_ni #(.LOOPBACK(0)) dut_b (
      .clk(clk), .rst(rst), .my_cluster(my_cluster), .my_local(my_local),
      .pe_data_in(pe_data_in), .pe_dst_cluster(pe_dst_cluster), .pe_dst_local(pe_dst_local),
      .pe_valid(pe_valid), .pe_ready(pe_ready_b), .inj_flit(inj_flit_b), .inj_valid(inj_valid_b),
      .inj_credit(inj_credit), .ej_flit(ej_flit), .ej_valid(ej_valid), .ej_credit(ej_credit_b),
      .pe_data_out(pe_data_out_b), .pe_out_valid(pe_out_valid_b), .pe_out_ready(pe_out_ready),
      .sent_cnt(sent_cnt_b), .recv_cnt(recv_cnt_b), .err(err_b)
   );

   always #5 clk = ~clk;

   // One comparison: count it and report any difference.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive every input for one cycle, then sample #1 after the rising edge.
   task automatic applyStimulus(input logic pv, input logic [15:0] dat, input logic [3:0] dst,
                                input logic ic, input logic ev, input logic [19:0] ef,
                                input logic por);
      logic acc;
      pe_valid = pv;
      pe_data_in = dat;
      {pe_dst_cluster, pe_dst_local} = dst;
      inj_credit = ic;
      ej_valid = ev;
      ej_flit = ef;
      pe_out_ready = por;
      acc = pv && pe_ready;
      @(posedge clk);
      #1;
      if (acc) accepts++;
      if (inj_valid) inj_pulses++;
      if (ej_credit) ejc_pulses++;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 20'h0, 1'b0);
   endtask

   task automatic doReset(input logic [3:0] own);
      rst = 1'b1;
      {my_cluster, my_local} = own;
      pe_valid = 1'b0; pe_data_in = '0; pe_dst_cluster = '0; pe_dst_local = '0;
      inj_credit = 1'b0; ej_valid = 1'b0; ej_flit = '0; pe_out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      accepts = 0; inj_pulses = 0; ejc_pulses = 0;
   endtask

   task automatic checkResetState();
      checkOutput("rst_inj_valid", 32'(inj_valid), 32'h0);
      checkOutput("rst_inj_flit", 32'(inj_flit), 32'h0);
      checkOutput("rst_ej_credit", 32'(ej_credit), 32'h0);
      checkOutput("rst_pe_out_valid", 32'(pe_out_valid), 32'h0);
      checkOutput("rst_pe_data_out", 32'(pe_data_out), 32'h0);
      checkOutput("rst_pe_ready", 32'(pe_ready), 32'h1);
      checkOutput("rst_sent_cnt", 32'(sent_cnt), 32'h0);
      checkOutput("rst_recv_cnt", 32'(recv_cnt), 32'h0);
      checkOutput("rst_err", 32'(err), 32'h0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      doReset(4'h0);
      checkResetState();

      // Credit exhaustion: node (0,0) sends six words to (1,2) with four credits.
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 16'(16'h1000 + i), 4'h6, 1'b0, 1'b0, 20'h0, 1'b0);
      idle(3);
      checkOutput("exh_pulses", 32'(inj_pulses), 32'd4);
      checkOutput("exh_sent", 32'(sent_cnt), 32'd4);
      checkOutput("exh_accepts", 32'(accepts), 32'd6);
      applyStimulus(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 20'h0, 1'b0);
      checkOutput("exh_credit_edge", 32'(inj_valid), 32'h0);
      idle(1);
      checkOutput("exh_fifth_valid", 32'(inj_valid), 32'h1);
      checkOutput("exh_fifth_flit", 32'(inj_flit), 32'h61004);
      checkOutput("exh_sent5", 32'(sent_cnt), 32'd5);

      // Back-pressure with credits drained, then credit coinciding with a send.
      doReset(4'h0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'(16'h2000 + i), 4'h6, 1'b0, 1'b0, 20'h0, 1'b0);
      idle(4);
      checkOutput("bp_drain_pulses", 32'(inj_pulses), 32'd4);
      accepts = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 16'(16'h3000 + i), 4'h6, 1'b0, 1'b0, 20'h0, 1'b0);
         if (i == 2) checkOutput("bp_ready_3rd", 32'(pe_ready), 32'h1);
         if (i == 3) checkOutput("bp_ready_4th", 32'(pe_ready), 32'h0);
      end
      checkOutput("bp_accepts", 32'(accepts), 32'd4);
      checkOutput("bp_ready_held", 32'(pe_ready), 32'h0);
      applyStimulus(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 20'h0, 1'b0);
      checkOutput("sim_no_send_yet", 32'(inj_valid), 32'h0);
      applyStimulus(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 20'h0, 1'b0);
      checkOutput("sim_send1", 32'(inj_valid), 32'h1);
      checkOutput("sim_flit1", 32'(inj_flit), 32'h63000);
      checkOutput("sim_ready_back", 32'(pe_ready), 32'h1);
      idle(1);
      checkOutput("sim_send2", 32'(inj_valid), 32'h1);
      checkOutput("sim_flit2", 32'(inj_flit), 32'h63001);
      idle(1);
      checkOutput("sim_stop", 32'(inj_valid), 32'h0);
      checkOutput("sim_sent", 32'(sent_cnt), 32'd6);
      checkOutput("sim_err", 32'(err), 32'h0);

      // Extra credit at full count is ignored and flagged.
      doReset(4'h0);
      applyStimulus(1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 20'h0, 1'b0);
      checkOutput("err0_set", 32'(err), 32'h1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'(16'h7000 + i), 4'h6, 1'b0, 1'b0, 20'h0, 1'b0);
      idle(4);
      checkOutput("err0_credits_capped", 32'(inj_pulses), 32'd4);

      // Ejection: three router flits buffered, then drained.
      doReset(4'h6);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, {4'h6, 16'(16'hA001 + i)}, 1'b0);
         if (i == 0) begin
            checkOutput("ej_latency_valid", 32'(pe_out_valid), 32'h1);
            checkOutput("ej_latency_data", 32'(pe_data_out), 32'hA001);
         end
      end
      for (int i = 0; i < 3; i++) begin
         checkOutput("ej_order", 32'(pe_data_out), 32'(16'hA001 + i));
         applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 20'h0, 1'b1);
         checkOutput("ej_credit_pulse", 32'(ej_credit), 32'h1);
      end
      checkOutput("ej_empty_valid", 32'(pe_out_valid), 32'h0);
      checkOutput("ej_empty_data", 32'(pe_data_out), 32'h0);
      idle(1);
      checkOutput("ej_credit_end", 32'(ej_credit), 32'h0);
      checkOutput("ej_credit_count", 32'(ejc_pulses), 32'd3);
      checkOutput("ej_recv", 32'(recv_cnt), 32'd3);
      checkOutput("ej_err", 32'(err), 32'h0);

      // Ejection overflow and misrouted flit.
      doReset(4'h6);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, {4'h6, 16'(16'hB000 + i)}, 1'b0);
      checkOutput("err1_set", 32'(err), 32'h2);
      for (int i = 0; i < 4; i++) begin
         checkOutput("err1_order", 32'(pe_data_out), 32'(16'hB000 + i));
         applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 20'h0, 1'b1);
      end
      checkOutput("err1_dropped", 32'(pe_out_valid), 32'h0);
      checkOutput("err1_recv", 32'(recv_cnt), 32'd4);
      applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, {4'hF, 16'hD00D}, 1'b0);
      checkOutput("err2_set", 32'(err), 32'h6);
      checkOutput("err2_delivered", 32'(pe_data_out), 32'hD00D);

      // Loopback at (2,3): wait for the credit-return gap, then move locally.
      doReset(4'hB);
      applyStimulus(1'b1, 16'hBEEF, 4'hB, 1'b0, 1'b1, {4'hB, 16'h1111}, 1'b0);
      checkOutput("lb_net_head", 32'(pe_data_out), 32'h1111);
      applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 20'h0, 1'b1);
      checkOutput("lb0_inj_valid", 32'(inj_valid_b), 32'h1);
      checkOutput("lb0_inj_flit", 32'(inj_flit_b), 32'hBBEEF);
      checkOutput("lb_net_credit", 32'(ej_credit), 32'h1);
      idle(1);
      checkOutput("lb_valid", 32'(pe_out_valid), 32'h1);
      checkOutput("lb_data", 32'(pe_data_out), 32'hBEEF);
      applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 20'h0, 1'b1);
      checkOutput("lb_popped", 32'(pe_out_valid), 32'h0);
      idle(2);
      checkOutput("lb_no_local_credit", 32'(ejc_pulses), 32'd1);
      checkOutput("lb_no_inj", 32'(inj_pulses), 32'd0);
      checkOutput("lb_sent", 32'(sent_cnt), 32'd0);
      checkOutput("lb_recv", 32'(recv_cnt), 32'd2);

      // Router flit wins over a loopback candidate that would otherwise fit.
      doReset(4'hB);
      applyStimulus(1'b1, 16'hC0DE, 4'hB, 1'b0, 1'b1, {4'hB, 16'h1111}, 1'b0);
      applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 20'h0, 1'b1);
      applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, {4'hB, 16'h2222}, 1'b0);
      checkOutput("prio_net_first", 32'(pe_data_out), 32'h2222);
      idle(1);
      checkOutput("prio_still_net", 32'(pe_data_out), 32'h2222);
      applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 20'h0, 1'b1);
      checkOutput("prio_drained", 32'(pe_out_valid), 32'h0);
      idle(1);
      checkOutput("prio_local_valid", 32'(pe_out_valid), 32'h1);
      checkOutput("prio_local_data", 32'(pe_data_out), 32'hC0DE);

      // Asynchronous reset in the middle of traffic.
      doReset(4'h0);
      applyStimulus(1'b1, 16'h4000, 4'h6, 1'b0, 1'b1, {4'h0, 16'h5555}, 1'b0);
      applyStimulus(1'b1, 16'h4001, 4'h6, 1'b0, 1'b1, {4'h0, 16'h5556}, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      checkResetState();
      doReset(4'h0);
      idle(2);
      checkOutput("mid_rst_ej_flushed", 32'(pe_out_valid), 32'h0);
      checkOutput("mid_rst_inj_flushed", 32'(inj_pulses), 32'd0);
      checkOutput("mid_rst_no_credit", 32'(ejc_pulses), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
